// File: rtl/ltc2195_lane_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ltc2195_lane_tx_pkg
// Description : Shared link constants for the LTC2195 2-lane LVDS transmit
//               and receive paths: word/lane geometry, test-pattern words
//               and FSM encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ltc2195_lane_tx_pkg;

  localparam int LTC_WORD_W    = 16;
  localparam int LTC_LANE_BITS = 8;   // serial bits per lane per frame
  localparam int LTC_LANES     = 2;   // lanes per channel
  localparam int LTC_SLOT_W    = $clog2(LTC_LANE_BITS);

  localparam logic [LTC_WORD_W-1:0] LTC_PAT_A = 16'hAAAA;
  localparam logic [LTC_WORD_W-1:0] LTC_PAT_B = 16'h5555;

  localparam logic [LTC_SLOT_W-1:0] LTC_SLOT_LAST = LTC_SLOT_W'(LTC_LANE_BITS - 1);
  // Last slot that still has FR high (first half of the frame).
  localparam logic [LTC_SLOT_W-1:0] LTC_FR_LAST   = LTC_SLOT_W'(LTC_LANE_BITS / 2 - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ltc_state_e;

endpackage : ltc2195_lane_tx_pkg
`default_nettype wire

// File: rtl/ltc2195_lane_ser.sv
`default_nettype none
// ============================================================================
// Module      : ltc2195_lane_ser
// Description : One channel of the LTC2195 transmitter. Holds the shadow
//               word (last accepted sample) and shifts a frame word out
//               MSB-first over two lanes: lane[1] carries odd bits, lane[0]
//               even bits.
// Ports       : clk_in      - system clock
//               rst_in      - asynchronous active-low reset
//               i_capture   - store i_data into the shadow register
//               i_data      - new channel word
//               i_load      - start a frame: put slot 0 on the lanes
//               i_use_alt   - load i_alt_word instead of the data/shadow word
//               i_alt_word  - test-pattern word
//               i_shift     - advance to the next slot
//               i_clear     - drive lanes to 0 (idle)
//               o_lanes     - registered lane outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2195_lane_ser
  import ltc2195_lane_tx_pkg::*;
#(
  parameter logic [LTC_WORD_W-1:0] INIT_WORD = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  i_capture,
  input  logic [LTC_WORD_W-1:0] i_data,
  input  logic                  i_load,
  input  logic                  i_use_alt,
  input  logic [LTC_WORD_W-1:0] i_alt_word,
  input  logic                  i_shift,
  input  logic                  i_clear,
  output logic [LTC_LANES-1:0]  o_lanes
);

  logic [LTC_WORD_W-1:0] r_shadow;
  logic [LTC_WORD_W-1:0] r_sr;
  logic [LTC_LANES-1:0]  r_lanes;
  logic [LTC_WORD_W-1:0] w_data_word;
  logic [LTC_WORD_W-1:0] w_load_word;

  // A word captured in the same cycle as the load goes straight out; with no
  // capture the previous shadow word is retransmitted.
  always_comb begin
    w_data_word = i_capture ? i_data : r_shadow;
    w_load_word = i_use_alt ? i_alt_word : w_data_word;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_shadow <= INIT_WORD;
      r_sr     <= '0;
      r_lanes  <= '0;
    end else begin
      if (i_capture) begin
        r_shadow <= i_data;
      end
      if (i_load) begin
        r_lanes <= w_load_word[LTC_WORD_W-1 -: LTC_LANES];
        r_sr    <= {w_load_word[LTC_WORD_W-LTC_LANES-1:0], {LTC_LANES{1'b0}}};
      end else if (i_shift) begin
        r_lanes <= r_sr[LTC_WORD_W-1 -: LTC_LANES];
        r_sr    <= {r_sr[LTC_WORD_W-LTC_LANES-1:0], {LTC_LANES{1'b0}}};
      end else if (i_clear) begin
        r_lanes <= '0;
        r_sr    <= '0;
      end
    end
  end

  assign o_lanes = r_lanes;

endmodule : ltc2195_lane_ser
`default_nettype wire

// File: rtl/ltc2195_lane_tx.sv
`default_nettype none
// ============================================================================
// Module      : ltc2195_lane_tx
// Description : Transmit end of the LTC2195 2-lane serial LVDS link, used as
//               an ADC emulator / loopback source. Serialises one 16-bit word
//               per channel per frame with FR and DCO outputs. All outputs
//               are registered and single-ended.
// Ports       : clk_in       - system clock (only clock)
//               rst_in       - asynchronous active-low reset
//               enable_in    - stream frames; 0 stops at a frame boundary
//               pattern_in   - send AAAA/5555 alternating test pattern
//               ADC0_in      - channel-0 word
//               ADC1_in      - channel-1 word
//               valid_in     - word pair available
//               ready_out    - pair accepted this cycle when valid_in=1
//               DCO_out      - bit clock, rising mid-bit
//               FR_out       - frame marker, high for slots 0-3
//               D0_out       - channel-0 lanes [1]=odd bits [0]=even bits
//               D1_out       - channel-1 lanes
//               underrun_out - pulse when a frame starts without new data
// Revision    : 1.0 - initial release
// ============================================================================
module ltc2195_lane_tx
  import ltc2195_lane_tx_pkg::*;
#(
  parameter int                    BIT_CYCLES = 2,
  parameter logic [LTC_WORD_W-1:0] INIT_WORD  = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic                  pattern_in,
  input  logic [LTC_WORD_W-1:0] ADC0_in,
  input  logic [LTC_WORD_W-1:0] ADC1_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  DCO_out,
  output logic                  FR_out,
  output logic [LTC_LANES-1:0]  D0_out,
  output logic [LTC_LANES-1:0]  D1_out,
  output logic                  underrun_out
);

  localparam int              BC_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_PRE  = BC_W'(BIT_CYCLES - 2);
  localparam logic [BC_W-1:0] BC_HALF = BC_W'(BIT_CYCLES / 2);

  ltc_state_e            r_state;
  ltc_state_e            w_state_next;
  logic [BC_W-1:0]       r_bc;
  logic [BC_W-1:0]       w_bc_next;
  logic                  w_bc_wrap;
  logic [LTC_SLOT_W-1:0] r_sc;
  logic                  r_ready;
  logic                  r_fr;
  logic                  r_dco;
  logic                  r_underrun;
  logic                  r_pat_phase;
  logic                  w_ready_next;
  logic                  w_start;
  logic                  w_shift;
  logic                  w_clear;
  logic                  w_capture;
  logic [LTC_WORD_W-1:0] w_pat_word;

  assign w_bc_wrap = (r_bc == BC_LAST);
  assign w_bc_next = w_bc_wrap ? '0 : r_bc + 1'b1;

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and frame strobes. A frame starts exactly when ready was
  // offered in the last cycle of the bit, so ready_out always predicts the
  // start and a late enable_in drop cannot strand an accepted word.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    if (w_bc_wrap) begin
      if (r_ready) begin
        w_start      = 1'b1;
        w_state_next = ST_RUN;
      end else if ((r_state == ST_RUN) && (r_sc != LTC_SLOT_LAST)) begin
        w_shift      = 1'b1;
      end else begin
        w_clear      = 1'b1;
        w_state_next = ST_IDLE;
      end
    end
    // Decided one cycle ahead: the bc value before the last cycle of a bit
    // never coincides with a wrap, so state/slot are stable across it.
    w_ready_next = enable_in && (r_bc == BC_PRE) &&
                   ((r_state == ST_IDLE) || (r_sc == LTC_SLOT_LAST));
    w_capture    = w_start && valid_in && !pattern_in;
    w_pat_word   = r_pat_phase ? LTC_PAT_B : LTC_PAT_A;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_bc        <= '0;
      r_sc        <= '0;
      r_ready     <= 1'b0;
      r_fr        <= 1'b0;
      r_dco       <= 1'b0;
      r_underrun  <= 1'b0;
      r_pat_phase <= 1'b0;
    end else begin
      r_bc       <= w_bc_next;
      // Registered from the next bc so DCO_out lines up with the current bc.
      r_dco      <= (w_bc_next >= BC_HALF);
      r_ready    <= w_ready_next;
      r_underrun <= w_start && !valid_in;
      if (w_start) begin
        r_sc        <= '0;
        r_fr        <= 1'b1;
        // Phase restarts on data frames so every pattern run opens with AAAA.
        r_pat_phase <= pattern_in ? ~r_pat_phase : 1'b0;
      end else if (w_shift) begin
        r_sc <= r_sc + 1'b1;
        r_fr <= (r_sc < LTC_FR_LAST);
      end else if (w_clear) begin
        r_sc <= '0;
        r_fr <= 1'b0;
      end
    end
  end

  ltc2195_lane_ser #(
    .INIT_WORD (INIT_WORD)
  ) u_ser0 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_capture  (w_capture),
    .i_data     (ADC0_in),
    .i_load     (w_start),
    .i_use_alt  (pattern_in),
    .i_alt_word (w_pat_word),
    .i_shift    (w_shift),
    .i_clear    (w_clear),
    .o_lanes    (D0_out)
  );

  ltc2195_lane_ser #(
    .INIT_WORD (INIT_WORD)
  ) u_ser1 (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_capture  (w_capture),
    .i_data     (ADC1_in),
    .i_load     (w_start),
    .i_use_alt  (pattern_in),
    .i_alt_word (w_pat_word),
    .i_shift    (w_shift),
    .i_clear    (w_clear),
    .o_lanes    (D1_out)
  );

  assign ready_out    = r_ready;
  assign DCO_out      = r_dco;
  assign FR_out       = r_fr;
  assign underrun_out = r_underrun;

endmodule : ltc2195_lane_tx
`default_nettype wire

// File: tb/tb_ltc2195_lane_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltc2195_lane_tx
// Description : Self-checking bench for ltc2195_lane_tx with BIT_CYCLES=2.
//               A model predicts each frame's words and underrun flag when
//               ready_out is offered; the monitor deserialises the lanes and
//               compares against the queued prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltc2195_lane_tx;

  localparam int          BC   = 2;
  localparam int          FLEN = 8 * BC;
  localparam logic [15:0] INIT = 16'h0000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        enable_in;
  logic        pattern_in;
  logic [15:0] ADC0_in;
  logic [15:0] ADC1_in;
  logic        valid_in;
  logic        ready_out;
  logic        DCO_out;
  logic        FR_out;
  logic [1:0]  D0_out;
  logic [1:0]  D1_out;
  logic        underrun_out;

  ltc2195_lane_tx #(
    .BIT_CYCLES (BC),
    .INIT_WORD  (INIT)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .enable_in    (enable_in),
    .pattern_in   (pattern_in),
    .ADC0_in      (ADC0_in),
    .ADC1_in      (ADC1_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .DCO_out      (DCO_out),
    .FR_out       (FR_out),
    .D0_out       (D0_out),
    .D1_out       (D1_out),
    .underrun_out (underrun_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int tcyc     = 0;

  always @(posedge clk_in) tcyc <= tcyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] unlane(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = '0;
    for (int s = 0; s < 8; s++) begin
      w[15-2*s] = hi[7-s];
      w[14-2*s] = lo[7-s];
    end
    return w;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
    logic        ur;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic        in_frame = 1'b0;
  logic        pend     = 1'b0;
  int          fcyc     = 0;
  logic [15:0] m_sh0    = INIT;
  logic [15:0] m_sh1    = INIT;
  logic        m_phase  = 1'b0;
  logic [7:0]  h0, l0, h1, l1;
  logic [7:0]  last_d0h, last_d0l;
  logic [15:0] last_w0, last_w1;
  int          n_frames = 0;
  int          n_ur     = 0;

  always @(negedge clk_in) begin
    if (!rst_in) begin
      in_frame = 1'b0;
      pend     = 1'b0;
      fcyc     = 0;
      exp_q.delete();
      m_sh0    = INIT;
      m_sh1    = INIT;
      m_phase  = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        chk("frame_start_fr", FR_out, 1);
        cur = exp_q.pop_front();
        chk("underrun_pulse", underrun_out, cur.ur);
        in_frame = 1'b1;
        fcyc = 0;
        h0 = '0; l0 = '0; h1 = '0; l1 = '0;
      end else begin
        chk("underrun_quiet", underrun_out, 0);
        if (in_frame) begin
          fcyc++;
          if (fcyc == FLEN) in_frame = 1'b0;
        end
      end
      if (underrun_out) n_ur++;
      if (in_frame) begin
        chk("frame_fr", FR_out, (fcyc < FLEN / 2));
        chk("frame_dco", DCO_out, ((fcyc % BC) >= BC / 2));
        if ((fcyc % BC) == 0) begin
          h0 = {h0[6:0], D0_out[1]};
          l0 = {l0[6:0], D0_out[0]};
          h1 = {h1[6:0], D1_out[1]};
          l1 = {l1[6:0], D1_out[0]};
        end
        if (fcyc == FLEN - 1) begin
          last_d0h = h0;
          last_d0l = l0;
          last_w0  = unlane(h0, l0);
          last_w1  = unlane(h1, l1);
          chk("frame_word0", last_w0, cur.w0);
          chk("frame_word1", last_w1, cur.w1);
          n_frames++;
        end
      end else begin
        chk("idle_fr", FR_out, 0);
        chk("idle_lanes", {D0_out, D1_out}, 0);
      end
      if (ready_out) begin
        exp_t e;
        if (in_frame) chk("ready_slot", fcyc, FLEN - 1);
        e.ur = !valid_in;
        if (pattern_in) begin
          e.w0 = m_phase ? 16'h5555 : 16'hAAAA;
          e.w1 = e.w0;
          m_phase = ~m_phase;
        end else begin
          m_phase = 1'b0;
          if (valid_in) begin
            m_sh0 = ADC0_in;
            m_sh1 = ADC1_in;
          end
          e.w0 = m_sh0;
          e.w1 = m_sh1;
        end
        exp_q.push_back(e);
        pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_xfer(output int t);
    bit done;
    done = 1'b0;
    t    = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_in);
      if (ready_out && valid_in) begin
        done = 1'b1;
        t    = tcyc;
      end
    end
    chk("xfer_timeout", done, 1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_watch(input int n);
    int   c_fr, c_rdy, c_lane, c_tog;
    logic prev;
    c_fr = 0; c_rdy = 0; c_lane = 0; c_tog = 0;
    @(negedge clk_in);
    prev = DCO_out;
    for (int i = 1; i < n; i++) begin
      @(negedge clk_in);
      if (FR_out) c_fr++;
      if (ready_out) c_rdy++;
      if ({D0_out, D1_out} != 4'b0) c_lane++;
      if (DCO_out != prev) c_tog++;
      prev = DCO_out;
    end
    chk("idle_win_fr", c_fr, 0);
    chk("idle_win_ready", c_rdy, 0);
    chk("idle_win_lanes", c_lane, 0);
    chk("idle_win_dco_toggles", c_tog, n - 1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ready"}, ready_out, 0);
    chk({p, "_dco"}, DCO_out, 0);
    chk({p, "_fr"}, FR_out, 0);
    chk({p, "_d0"}, D0_out, 0);
    chk({p, "_d1"}, D1_out, 0);
    chk({p, "_underrun"}, underrun_out, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t, tprev, ur0, fr0;
    rst_in = 1'b0; enable_in = 1'b0; pattern_in = 1'b0; valid_in = 1'b0;
    ADC0_in = '0; ADC1_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset");
    rst_in = 1'b1;

    // Enable low: nothing is framed, DCO still runs.
    idle_watch(20);

    // Single word.
    ADC0_in = 16'hA5C3; ADC1_in = 16'h3C5A; valid_in = 1'b1; enable_in = 1'b1;
    wait_xfer(t);
    valid_in = 1'b0; enable_in = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    chk("single_d0_odd", last_d0h, 8'hC9);
    chk("single_d0_even", last_d0l, 8'h39);
    chk("single_frames", n_frames, 1);

    // Back-to-back, then underrun, then enable drop at slot 3.
    ur0 = n_ur;
    valid_in = 1'b1; enable_in = 1'b1;
    tprev = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: ADC1_in = 16'h0001;
        1: ADC1_in = 16'h8000;
        default: ADC1_in = 16'h1234;
      endcase
      ADC0_in = (i == 2) ? 16'h1234 : ~ADC1_in;
      wait_xfer(t);
      if (i > 0) chk("b2b_gap", t - tprev, FLEN);
      tprev = t;
    end
    valid_in = 1'b0;
    chk("b2b_no_underrun", n_ur - ur0, 0);
    repeat (23) @(posedge clk_in);
    #1;
    enable_in = 1'b0;
    repeat (15) @(posedge clk_in);
    #1;
    idle_watch(20);
    chk("underrun_count", n_ur - ur0, 1);
    chk("underrun_repeat_w1", last_w1, 16'h1234);
    chk("b2b_frames", n_frames, 5);

    // Pattern frames; input data is discarded.
    fr0 = n_frames;
    pattern_in = 1'b1; ADC0_in = 16'hDEAD; ADC1_in = 16'hBEEF;
    valid_in = 1'b1; enable_in = 1'b1;
    for (int i = 0; i < 3; i++) wait_xfer(t);
    valid_in = 1'b0; enable_in = 1'b0; pattern_in = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    chk("pattern_frames", n_frames - fr0, 3);
    chk("pattern_last_w0", last_w0, 16'hAAAA);
    chk("pattern_last_w1", last_w1, 16'hAAAA);

    // Reset mid-frame.
    ADC0_in = 16'h1111; ADC1_in = 16'h2222; valid_in = 1'b1; enable_in = 1'b1;
    wait_xfer(t);
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check_zero("midreset");
    enable_in = 1'b0; valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    check_zero("midreset_hold");
    rst_in = 1'b1;
    idle_watch(20);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ltc2195_lane_tx
`default_nettype wire
